snn_core_param: RTL
===================

Name: snn_core_param

Overview:
- Parametrised second-generation two-layer fully-connected inference core, hidden layer then output layer, with argmax classification.
- Generalises the fixed 784-32-10 binary-input core to arbitrary layer sizes and an optional multi-bit input mode.
- Weight ROMs, the input image memory and the activation LUT sit outside the block. Hidden-unit storage is internal.
- Also reports the winning score, a busy flag, and deterministic tie-breaking.

Parameters:
- N_IN, 784, input units per image.
- N_HID, 32, hidden units.
- N_OUT, 10, output units / classes.
- BIN_IN, 1. 1: in_data[0] is replicated to 8 bits. 0: in_data is an 8-bit signed pixel.
- ACC_W, 27, signed accumulator width.
- Derived widths: IW=$clog2(N_IN), HW=$clog2(N_HID), OW=$clog2(N_OUT).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  begin inference; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse, result valid
- digit  out  OW  index of the winning output unit
- max_score  out  8  activation of the winning unit, unsigned
- in_addr  out  IW  input memory address
- in_data  in  8  input memory data, 1-cycle read latency
- wh_addr  out  HW+IW  hidden weight ROM address = {hidden_idx, input_idx}
- wh_data  in  8  signed hidden weight, 1-cycle latency
- wo_addr  out  OW+HW  output weight ROM address = {output_idx, hidden_idx}
- wo_data  in  8  signed output weight, 1-cycle latency
- act_addr  out  11  activation LUT address
- act_data  in  8  unsigned activation, 1-cycle latency

Behaviour:
- Reset (asynchronous, rst=1):
  - State returns to IDLE.
  - busy=0, done=0, digit=0, max_score=0.
  - All address outputs and the accumulator go to 0.
  - Reset mid-run abandons the run with no done pulse.
- States: IDLE, HID_MAC, HID_DRAIN, HID_ACT, HID_WR, OUT_MAC, OUT_DRAIN, OUT_ACT, OUT_CMP, DONE.
- IDLE: clears the counters and accumulator. start=1 moves to HID_MAC. start in any other state is ignored.
- HID_MAC:
  - Issues in_addr=j and wh_addr={h,j} for j=0..N_IN-1, one per cycle.
  - Each returned pair is accumulated on the following cycle.
  - Operand A = BIN_IN ? {8{in_data[0]}} : in_data; operand B = wh_data. Both signed, so the product is signed 16-bit, sign-extended to ACC_W.
  - After j=N_IN-1, go to HID_DRAIN (last product accumulates).
- Activation, used by both layers:
  - s = acc >>> 7 (arithmetic shift).
  - Clamp s to [-1024, 1023].
  - act_addr = s + 1024, i.e. s[10:0] with the MSB inverted.
  - act_addr is registered in HID_ACT.
- HID_WR:
  - act_data is written to hidden RAM[h] and the accumulator is cleared.
  - If h==N_HID-1, clear h and go to OUT_MAC. Otherwise h++ and go to HID_MAC.
- OUT_MAC:
  - Reads hidden RAM[k] (registered read, 1-cycle latency) and wo_addr={o,k} for k=0..N_HID-1.
  - Operand A = hidden value, zero-extended to signed 9 bits. Operand B = wo_data.
  - Then OUT_DRAIN and OUT_ACT, using the same activation rule.
- OUT_CMP:
  - If o==0 or act_data > max_score (unsigned, strict), load digit=o and max_score=act_data.
  - Ties therefore keep the lowest index.
  - Clear the accumulator. If o==N_OUT-1 go to DONE, otherwise o++ and go to OUT_MAC.
- DONE: done=1 for one cycle, then IDLE. digit and max_score hold until the next run's first OUT_CMP.
- Latency: start sampled at edge E, done high in cycle E + N_HID*(N_IN+3) + N_OUT*(N_HID+3) + 1. With the defaults this is 25535.
- Accumulator:
  - Wraps modulo 2^ACC_W. Do not size parameters so that it overflows.
  - Clamping is applied only at the activation step.
- Address outputs are registered. Address values outside the issuing states are don't-care.

Test Plan:
- Reset: assert rst at cycle 1000 of a run -> same cycle busy=0, done=0, digit=0, max_score=0. No done follows. A new start then completes normally.
- Latency: defaults, single-cycle start -> done exactly 25535 cycles later, width 1. busy is high throughout and drops with done.
- Tie-break: act LUT returns constant 8'h80 -> digit=0, max_score=8'h80.
- Winner: act_data=act_addr[10:3]; wo_data=8'h40 for o=7, 8'h00 elsewhere; wh_data=8'h10; all input bits 1 -> digit=7, max_score > 8'h80.
- Saturation: BIN_IN=0, in_data=8'h7F, wh_data=8'h7F -> every hidden act_addr=11'h7FF. With wh_data=8'h81 -> act_addr=11'h000.
- start pulsed while busy and in DONE -> ignored, exactly one done per accepted start. start in IDLE the cycle after DONE -> accepted.

Source files
------------

// File: rtl/snn_core_param.sv
// Two-layer fully-connected inference core (hidden layer, output layer, argmax).
// Weight ROMs, input memory and activation LUT are external with 1-cycle read latency.
//
// state     | meaning
// IDLE      | waiting for start, counters and accumulator cleared
// HID_MAC   | issue input/hidden-weight addresses, accumulate returned pairs
// HID_DRAIN | accumulate last hidden product, register act_addr
// HID_ACT   | activation LUT lookup in flight
// HID_WR    | store activation in hidden RAM, next hidden unit
// OUT_MAC   | issue hidden RAM/output-weight addresses, accumulate
// OUT_DRAIN | accumulate last output product, register act_addr
// OUT_ACT   | activation LUT lookup in flight
// OUT_CMP   | running argmax update, next output unit
// DONE      | one-cycle result-valid pulse
module snn_core_param #(
   parameter int N_IN   = 784,
   parameter int N_HID  = 32,
   parameter int N_OUT  = 10,
   parameter int BIN_IN = 1,
   parameter int ACC_W  = 27,
   localparam int IW = $clog2(N_IN),
   localparam int HW = $clog2(N_HID),
   localparam int OW = $clog2(N_OUT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [OW-1:0]    digit,
   output logic [7:0]       max_score,
   output logic [IW-1:0]    in_addr,
   input  logic [7:0]       in_data,
   output logic [HW+IW-1:0] wh_addr,
   input  logic [7:0]       wh_data,
   output logic [OW+HW-1:0] wo_addr,
   input  logic [7:0]       wo_data,
   output logic [10:0]      act_addr,
   input  logic [7:0]       act_data
);

   typedef enum logic [3:0] {
      S_IDLE, S_HID_MAC, S_HID_DRAIN, S_HID_ACT, S_HID_WR,
      S_OUT_MAC, S_OUT_DRAIN, S_OUT_ACT, S_OUT_CMP, S_DONE
   } state_t;

   localparam logic [IW-1:0] J_LAST = IW'(N_IN - 1);
   localparam logic [HW-1:0] H_LAST = HW'(N_HID - 1);
   localparam logic [OW-1:0] O_LAST = OW'(N_OUT - 1);
   localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'(1023);
   localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(-1024);

   state_t state_q, state_d;
   logic [IW-1:0] j_q, j_d;
   logic [HW-1:0] h_q, h_d, k_q, k_d;
   logic [OW-1:0] o_q, o_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic vld_q;
   logic [10:0] act_q, act_d;
   logic [OW-1:0] digit_q, digit_d;
   logic [7:0] max_q, max_d;
   logic ram_we;
   logic [7:0] hid_ram [N_HID];
   logic [7:0] hid_q;

   logic signed [7:0]  op_a, op_w, op_v;
   logic signed [8:0]  op_h;
   logic signed [15:0] prod_h;
   logic signed [16:0] prod_o;
   logic signed [ACC_W-1:0] mac_sum;
   logic hid_phase;

   function automatic logic [10:0] act_index(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0] s;
      s = a >>> 7;
      if (s > S_MAX)      act_index = 11'h7FF;
      else if (s < S_MIN) act_index = 11'h000;
      else                act_index = {~s[10], s[9:0]};
   endfunction

   assign op_a   = (BIN_IN != 0) ? {8{in_data[0]}} : in_data;
   assign op_w   = wh_data;
   assign op_v   = wo_data;
   assign op_h   = {1'b0, hid_q};
   assign prod_h = 16'(op_a) * 16'(op_w);
   assign prod_o = 17'(op_h) * 17'(op_v);

   assign hid_phase = (state_q == S_HID_MAC) || (state_q == S_HID_DRAIN);
   assign mac_sum   = acc_q + (hid_phase ? ACC_W'(prod_h) : ACC_W'(prod_o));

   always_comb begin
      state_d = state_q;
      j_d     = j_q;
      h_d     = h_q;
      k_d     = k_q;
      o_d     = o_q;
      acc_d   = acc_q;
      act_d   = act_q;
      digit_d = digit_q;
      max_d   = max_q;
      ram_we  = 1'b0;
      // data returned for the previous cycle's address is summed here
      if (vld_q) acc_d = mac_sum;
      case (state_q)
         S_IDLE: begin
            j_d   = '0;
            h_d   = '0;
            k_d   = '0;
            o_d   = '0;
            acc_d = '0;
            if (start) state_d = S_HID_MAC;
         end
         S_HID_MAC: begin
            if (j_q == J_LAST) begin
               j_d     = '0;
               state_d = S_HID_DRAIN;
            end else begin
               j_d = j_q + 1'b1;
            end
         end
         S_HID_DRAIN: begin
            act_d   = act_index(mac_sum);
            state_d = S_HID_ACT;
         end
         S_HID_ACT: state_d = S_HID_WR;
         S_HID_WR: begin
            ram_we = 1'b1;
            acc_d  = '0;
            if (h_q == H_LAST) begin
               h_d     = '0;
               state_d = S_OUT_MAC;
            end else begin
               h_d     = h_q + 1'b1;
               state_d = S_HID_MAC;
            end
         end
         S_OUT_MAC: begin
            if (k_q == H_LAST) begin
               k_d     = '0;
               state_d = S_OUT_DRAIN;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         S_OUT_DRAIN: begin
            act_d   = act_index(mac_sum);
            state_d = S_OUT_ACT;
         end
         S_OUT_ACT: state_d = S_OUT_CMP;
         S_OUT_CMP: begin
            acc_d = '0;
            // strict compare keeps the lowest index on ties
            if ((o_q == '0) || (act_data > max_q)) begin
               digit_d = o_q;
               max_d   = act_data;
            end
            if (o_q == O_LAST) begin
               state_d = S_DONE;
            end else begin
               o_d     = o_q + 1'b1;
               state_d = S_OUT_MAC;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         j_q     <= '0;
         h_q     <= '0;
         k_q     <= '0;
         o_q     <= '0;
         acc_q   <= '0;
         vld_q   <= 1'b0;
         act_q   <= '0;
         digit_q <= '0;
         max_q   <= '0;
      end else begin
         state_q <= state_d;
         j_q     <= j_d;
         h_q     <= h_d;
         k_q     <= k_d;
         o_q     <= o_d;
         acc_q   <= acc_d;
         vld_q   <= (state_q == S_HID_MAC) || (state_q == S_OUT_MAC);
         act_q   <= act_d;
         digit_q <= digit_d;
         max_q   <= max_d;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) hid_ram[h_q] <= act_data;
      hid_q <= hid_ram[k_q];
   end

   assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
   assign done      = (state_q == S_DONE);
   assign digit     = digit_q;
   assign max_score = max_q;
   assign in_addr   = j_q;
   assign wh_addr   = {h_q, j_q};
   assign wo_addr   = {o_q, k_q};
   assign act_addr  = act_q;

endmodule
